// File: rtl/dmac_pkg.sv
// Shared FSM state encoding and burst-length helper for the DMA burst splitter.
package dmac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAddr,
        StData,
        StDone
    } dmac_state_e;

    function automatic logic [31:0] burst_min(
        input logic [31:0] remaining,
        input logic [31:0] room,
        input logic [31:0] max_len
    );
        logic [31:0] b;
        b = remaining;
        if (max_len < b) b = max_len;
        if (room < b) b = room;
        return b;
    endfunction

endpackage

// File: rtl/dmac_burst_calc.sv
// Registered burst sizing: min of remaining words, max burst and words left before the
// address boundary. Captures on en_i, which the top asserts in CALC.
module dmac_burst_calc
    import dmac_pkg::*;
#(
    parameter int unsigned W_D           = 32,
    parameter int unsigned W_SIZE        = 32,
    parameter int unsigned W_BOUNDARY_A  = 12,
    parameter int unsigned W_BLEN        = 8,
    parameter int unsigned MAX_BURST_LEN = 256,
    parameter int unsigned W_BURST       = $clog2(MAX_BURST_LEN) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [W_BOUNDARY_A-1:0] addr_lo_i,
    input  logic [W_SIZE-1:0]       remaining_i,
    output logic [W_BURST-1:0]      burst_o,
    output logic [W_BLEN-1:0]       len_o
);

    localparam int unsigned ROOM_W  = W_BOUNDARY_A + 1;
    localparam int unsigned BYTE_SH = $clog2(W_D / 8);

    logic [ROOM_W-1:0] room_bytes;
    logic [ROOM_W-1:0] room_words;
    logic [31:0]       burst;

    // Address is word aligned, so the byte room divides exactly into words.
    always_comb begin
        room_bytes = (ROOM_W'(1) << W_BOUNDARY_A) - ROOM_W'(addr_lo_i);
        room_words = room_bytes >> BYTE_SH;
        burst      = burst_min(32'(remaining_i), 32'(room_words), 32'(MAX_BURST_LEN));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_o <= '0;
            len_o   <= '0;
        end else if (en_i) begin
            burst_o <= W_BURST'(burst);
            len_o   <= W_BLEN'(burst - 32'd1);
        end
    end

endmodule

// File: rtl/dmac_burst_splitter.sv
// Splits a word-count DMA request into AXI bursts that never cross the boundary.
// Optional macro DMAC_BURST_SPLITTER_PERF_EN adds the perf_cycles busy-cycle counter.
module dmac_burst_splitter
    import dmac_pkg::*;
#(
    parameter int unsigned W_D           = 32,
    parameter int unsigned W_EXT_A       = 32,
    parameter int unsigned W_SIZE        = 32,
    parameter int unsigned W_BOUNDARY_A  = 12,
    parameter int unsigned W_BLEN        = 8,
    parameter int unsigned MAX_BURST_LEN = 256
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [W_EXT_A-1:0] req_addr,
    input  logic [W_SIZE-1:0]  req_size,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [W_D-1:0]     src_data,
    output logic               dst_valid,
    input  logic               dst_ready,
    output logic [W_D-1:0]     dst_data,
    output logic               awvalid,
    input  logic               awready,
    output logic [W_EXT_A-1:0] awaddr,
    output logic [W_BLEN-1:0]  awlen,
    output logic               wvalid,
    input  logic               wready,
    output logic [W_D-1:0]     wdata,
    output logic [W_D/8-1:0]   wstrb,
    output logic               wlast,
    output logic               arvalid,
    input  logic               arready,
    output logic [W_EXT_A-1:0] araddr,
    output logic [W_BLEN-1:0]  arlen,
    input  logic               rvalid,
    output logic               rready,
    input  logic [W_D-1:0]     rdata,
    input  logic               rlast,
    output logic               done
`ifdef DMAC_BURST_SPLITTER_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    localparam int unsigned W_BURST = $clog2(MAX_BURST_LEN) + 1;
    localparam int unsigned BYTE_SH = $clog2(W_D / 8);

    dmac_state_e        state_q;
    logic               write_q;
    logic [W_EXT_A-1:0] addr_q;
    logic [W_SIZE-1:0]  rem_q;
    logic [W_BLEN-1:0]  beat_q;
    logic               awvalid_q;
    logic               arvalid_q;
    logic               done_q;

    logic [W_BURST-1:0] burst;
    logic [W_BLEN-1:0]  len;
    logic               data_wr;
    logic               data_rd;
    logic               beat_fire;
    logic               addr_fire;
    logic               unused_rlast;

    dmac_burst_calc #(
        .W_D           (W_D),
        .W_SIZE        (W_SIZE),
        .W_BOUNDARY_A  (W_BOUNDARY_A),
        .W_BLEN        (W_BLEN),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .W_BURST       (W_BURST)
    ) u_calc (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .en_i        (state_q == StCalc),
        .addr_lo_i   (addr_q[W_BOUNDARY_A-1:0]),
        .remaining_i (rem_q),
        .burst_o     (burst),
        .len_o       (len)
    );

    // Burst termination relies on the internal beat count only.
    assign unused_rlast = rlast;

    always_comb begin
        data_wr   = (state_q == StData) && write_q;
        data_rd   = (state_q == StData) && !write_q;
        beat_fire = (data_wr && src_valid && wready) || (data_rd && rvalid && dst_ready);
        addr_fire = write_q ? awready : arready;
        req_ready = (state_q == StIdle) && !ARESET;
        wvalid    = data_wr && src_valid;
        src_ready = data_wr && wready;
        wdata     = src_data;
        wstrb     = {(W_D / 8){data_wr}};
        wlast     = data_wr && (beat_q == len);
        dst_valid = data_rd && rvalid;
        rready    = data_rd && dst_ready;
        dst_data  = rdata;
        awvalid   = awvalid_q;
        arvalid   = arvalid_q;
        awaddr    = addr_q;
        araddr    = addr_q;
        awlen     = len;
        arlen     = len;
        done      = done_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        rem_q   <= req_size;
                        beat_q  <= '0;
                        state_q <= (req_size == '0) ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    awvalid_q <= write_q;
                    arvalid_q <= !write_q;
                    state_q   <= StAddr;
                end
                StAddr: begin
                    if (addr_fire) begin
                        awvalid_q <= 1'b0;
                        arvalid_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (beat_fire) begin
                        if (beat_q == len) begin
                            beat_q  <= '0;
                            addr_q  <= addr_q + (W_EXT_A'(burst) << BYTE_SH);
                            rem_q   <= rem_q - W_SIZE'(burst);
                            state_q <= (rem_q == W_SIZE'(burst)) ? StDone : StCalc;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DMAC_BURST_SPLITTER_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            perf_q <= '0;
        end else if (state_q == StIdle) begin
            if (req_valid) perf_q <= '0;
        end else begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_dmac_burst_splitter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_dmac_burst_splitter;

    logic        ACLK, ARESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_size;
    logic        src_valid, src_ready;
    logic [31:0] src_data;
    logic        dst_valid, dst_ready;
    logic [31:0] dst_data;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic        done;
`ifdef DMAC_BURST_SPLITTER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    dmac_burst_splitter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .done(done)
`ifdef DMAC_BURST_SPLITTER_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got 0x%0h expected no event", name, act);
    endtask

    logic [31:0] exp_aw_addr[$];
    int          exp_aw_len[$];
    logic [31:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [31:0] exp_w_data[$];
    bit          exp_w_last[$];
    logic [31:0] exp_dst[$];
    int          done_pend = 0;
    int          dst_cnt = 0;
    int          w_next = 0;

    logic [31:0] pend_addr[$];
    int          pend_len[$];
    bit          r_hs = 0, w_hs = 0, rst_s = 1;

    always @(negedge ACLK) begin
        rst_s = ARESET;
        r_hs  = rvalid && rready && !ARESET;
        w_hs  = wvalid && wready && !ARESET;
        if (!ARESET) begin
            if (awvalid && awready) begin
                if (exp_aw_addr.size() == 0) fail_evt("aw_unexpected", awaddr);
                else begin
                    chk("awaddr", awaddr, exp_aw_addr.pop_front());
                    chk("awlen", awlen, exp_aw_len.pop_front());
                end
            end
            if (arvalid && arready) begin
                pend_addr.push_back(araddr);
                pend_len.push_back(int'(arlen));
                if (exp_ar_addr.size() == 0) fail_evt("ar_unexpected", araddr);
                else begin
                    chk("araddr", araddr, exp_ar_addr.pop_front());
                    chk("arlen", arlen, exp_ar_len.pop_front());
                end
            end
            if (wvalid && wready) begin
                if (exp_w_data.size() == 0) fail_evt("w_unexpected", wdata);
                else begin
                    chk("wdata", wdata, exp_w_data.pop_front());
                    chk("wlast", wlast, exp_w_last.pop_front());
                    chk("wstrb", wstrb, 4'hF);
                end
            end
            if (dst_valid && dst_ready) begin
                dst_cnt++;
                if (exp_dst.size() == 0) fail_evt("dst_unexpected", dst_data);
                else chk("dst_data", dst_data, exp_dst.pop_front());
            end
            if (done) begin
                if (done_pend == 0) fail_evt("done_unexpected", done);
                else done_pend--;
            end
        end
    end

    // Read slave: returns each word's own byte address as data.
    int r_beat = 0;
    initial begin
        rvalid = 0; rdata = 0; rlast = 0;
        forever begin
            @(posedge ACLK); #2;
            if (rst_s) begin
                pend_addr.delete(); pend_len.delete(); r_beat = 0;
            end else if (r_hs) begin
                if (r_beat == pend_len[0]) begin
                    void'(pend_addr.pop_front()); void'(pend_len.pop_front()); r_beat = 0;
                end else r_beat++;
            end
            if (pend_addr.size() > 0) begin
                rvalid = 1; rdata = pend_addr[0] + 32'(4 * r_beat); rlast = (r_beat == pend_len[0]);
            end else begin
                rvalid = 0; rlast = 0;
            end
        end
    end

    int w_idx = 0;
    initial begin
        src_valid = 0; src_data = 0;
        forever begin
            @(posedge ACLK); #2;
            if (w_hs) w_idx++;
            src_valid = 1;
            src_data  = 32'hA000_0000 + 32'(w_idx);
        end
    end

    task automatic push_aw(input logic [31:0] a, input int l);
        exp_aw_addr.push_back(a); exp_aw_len.push_back(l);
    endtask
    task automatic push_ar(input logic [31:0] a, input int l);
        exp_ar_addr.push_back(a); exp_ar_len.push_back(l);
    endtask
    task automatic push_w_burst(input int n);
        for (int i = 0; i < n; i++) begin
            exp_w_data.push_back(32'hA000_0000 + 32'(w_next)); exp_w_last.push_back(i == n - 1);
            w_next++;
        end
    endtask
    task automatic push_dst(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_dst.push_back(a + 32'(4 * i));
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] sz);
        bit ok;
        ok = 0;
        @(posedge ACLK); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_size = sz;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (req_ready) begin ok = 1; break; end
        end
        chk("req_accepted", ok, 1);
        @(posedge ACLK); #1;
        req_valid = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000 && done_pend > 0; i++) @(negedge ACLK);
        chk({"done_", name}, done_pend, 0);
        @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        ARESET = 1; req_valid = 0; req_write = 0; req_addr = 0; req_size = 0;
        dst_ready = 1; awready = 1; wready = 1; arready = 1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_done", done, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        chk("idle_req_ready", req_ready, 1);

        // Single write burst.
        push_aw(32'h1000, 3); push_w_burst(4); done_pend++;
        issue(1, 32'h1000, 4);
        wait_done("wr4");

        // Read crossing the 4KB boundary.
        push_ar(32'h0FF8, 1); push_ar(32'h1000, 5); push_dst(32'h0FF8, 8); done_pend++;
        issue(0, 32'h0FF8, 8);
        wait_done("rd8");

        // Write longer than the maximum burst.
        push_aw(32'h0, 255); push_w_burst(256); push_aw(32'h400, 43); push_w_burst(44);
        done_pend++;
        issue(1, 32'h0, 300);
        wait_done("wr300");

        // Zero-length request.
        done_pend++;
        issue(1, 32'h5000, 0);
        @(negedge ACLK);
        chk("sz0_done_c1", done, 0);
        chk("sz0_awvalid_c1", awvalid, 0);
        @(negedge ACLK);
        chk("sz0_done_c2", done, 1);
        chk("sz0_awvalid_c2", awvalid, 0);
        chk("sz0_arvalid_c2", arvalid, 0);
        wait_done("sz0");

        // Address backpressure.
        awready = 0;
        push_aw(32'h2000, 1); push_w_burst(2); done_pend++;
        issue(1, 32'h2000, 2);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (awvalid) begin seen = 1; break; end
        end
        chk("aw_stall_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("aw_stall_valid", awvalid, 1);
            chk("aw_stall_addr", awaddr, 32'h2000);
            chk("aw_stall_len", awlen, 1);
            chk("aw_stall_wvalid", wvalid, 0);
        end
        @(posedge ACLK); #1 awready = 1;
        wait_done("awstall");

        // Reset during the 3rd beat of a 16-beat read.
        base = dst_cnt;
        push_ar(32'h3000, 15); push_dst(32'h3000, 2);
        issue(0, 32'h3000, 16);
        for (int i = 0; i < 100; i++) begin
            @(posedge ACLK);
            if (dst_cnt >= base + 2) break;
        end
        chk("rst_mid_beats", dst_cnt - base, 2);
        #1 ARESET = 1;
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_dst_valid", dst_valid, 0);
        chk("abort_arvalid", arvalid, 0);
        repeat (5) @(negedge ACLK);
        chk("abort_dst_left", exp_dst.size(), 0);

        push_ar(32'h3100, 1); push_dst(32'h3100, 2); done_pend++;
        issue(0, 32'h3100, 2);
        wait_done("after_abort");

        repeat (3) @(negedge ACLK);
        chk("end_aw_q", exp_aw_addr.size(), 0);
        chk("end_ar_q", exp_ar_addr.size(), 0);
        chk("end_w_q", exp_w_data.size(), 0);
        chk("end_dst_q", exp_dst.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmac_burst_splitter.md
DMAC_BURST_SPLITTER -- requirements
Module: dmac_burst_splitter

Interface
REQ-001 SHALL have parameter W_D, default 32, data width (power of 2, at least 8).
REQ-002 SHALL have parameter W_EXT_A, default 32, byte address width.
REQ-003 SHALL have parameter W_SIZE, default 32, request length width (words).
REQ-004 SHALL have parameter W_BOUNDARY_A, default 12, no-cross boundary width (4KB).
REQ-005 SHALL have parameter W_BLEN, default 8, AXI len width.
REQ-006 SHALL have parameter MAX_BURST_LEN, default 256, maximum beats per burst.
REQ-007 SHALL have ports ACLK, input, 1, sole clock; ARESET, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports req_valid/req_ready, in/out, 1, request handshake; req_write, in, 1 (1 = write); req_addr, in, W_EXT_A, word-aligned byte address; req_size, in, W_SIZE, length in words.
REQ-009 SHALL have ports src_valid/src_ready/src_data, in/out/in, 1/1/W_D, write data stream; dst_valid/dst_ready/dst_data, out/in/out, 1/1/W_D, read data stream.
REQ-010 SHALL have ports awvalid/awready/awaddr/awlen, out/in/out/out, 1/1/W_EXT_A/W_BLEN; wvalid/wready/wdata/wstrb/wlast, out/in/out/out/out; arvalid/arready/araddr/arlen; rvalid/rready/rdata/rlast.
REQ-011 SHALL have port done, output, 1, single-cycle pulse when the whole request completes.

Function
REQ-012 SHALL run FSM IDLE -> CALC -> ADDR -> DATA -> (CALC if words remain, else DONE) -> IDLE.
REQ-013 SHALL assert req_ready only in IDLE and latch write, addr and size on req_valid && req_ready.
REQ-014 SHALL go from IDLE directly to DONE when the latched size is 0, with no address or data beats.
REQ-015 SHALL compute burst in CALC as min(remaining, MAX_BURST_LEN, (2^W_BOUNDARY_A - addr[W_BOUNDARY_A-1:0]) / (W_D/8)) and register len = burst-1.
REQ-016 SHALL hold awvalid (write) or arvalid (read) with stable addr and len in ADDR until the matching ready is sampled high, then enter DATA.
REQ-017 SHALL have at most one burst outstanding; a new address SHALL NOT be issued before the last beat of the current burst.
REQ-018 SHALL, for writes, connect wvalid = src_valid, src_ready = wready, wdata = src_data and wstrb all ones, active only in DATA; wlast SHALL be high on beat len+1.
REQ-019 SHALL, for reads, connect dst_valid = rvalid, rready = dst_ready, dst_data = rdata, active only in DATA; the last beat SHALL be counted internally, and rlast SHALL NOT be used for termination.
REQ-020 SHALL count a beat only on valid && ready; on the final beat addr advances by burst*(W_D/8) and remaining decreases by burst.
REQ-021 SHALL wrap address arithmetic modulo 2^W_EXT_A.
REQ-022 SHALL assert done for exactly one cycle in DONE, then return to IDLE.

Reset
REQ-023 SHALL on ARESET drive the FSM to IDLE and all valid, ready, last and done outputs to 0; awaddr, araddr, awlen and arlen SHALL reset to 0.
REQ-024 SHALL let ARESET abort an in-flight request immediately with no done pulse; in-flight data SHALL be dropped.

Configuration
REQ-025 SHALL, with macro DMAC_BURST_SPLITTER_PERF_EN defined, provide output perf_cycles (32 bit), counting cycles not in IDLE and cleared on request acceptance and on reset.
REQ-026 SHALL, with DMAC_BURST_SPLITTER_PERF_EN undefined, omit the perf_cycles port and its counter.

Structure
REQ-027 SHALL place the FSM state encoding and the burst-length function in shared package dmac_pkg.
REQ-028 SHALL use one sub-module dmac_burst_calc, a registered min/boundary computation used in CALC.

Verification (W_D=32)
REQ-029 SHALL cover: write addr 0x1000 size 4 -> one AW awaddr 0x1000 awlen 3; 4 W beats with wlast on the 4th; done.
REQ-030 SHALL cover: read addr 0x0FF8 size 8 -> AR 0x0FF8 len 1, then AR 0x1000 len 5; 8 dst beats; one done.
REQ-031 SHALL cover: write addr 0x0 size 300 -> AW len 255 at 0x0, then AW len 43 at 0x400.
REQ-032 SHALL cover: size 0 -> done two cycles after acceptance; no awvalid or arvalid.
REQ-033 SHALL cover: awready held low 5 cycles -> awvalid, awaddr and awlen stable throughout; no W beats until acceptance.
REQ-034 SHALL cover: ARESET on the 3rd beat of a 16-beat read -> next cycle in IDLE, req_ready 1, no done; a following request completes normally.
